// File: rtl/debug_clock_ctrl_if.sv
// Control/observation bundle for debug_clock_ctrl: pacing controls in, tick and watch status out.
interface debug_clock_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       mode;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             step;
  logic [WIDTH-1:0] watch;
  logic             tick;
  logic             halted;
  logic [WIDTH-1:0] watch_q;
  logic             changed;
  logic [CNT_W-1:0] change_count;

  modport master (
    output mode, div_load, div_value, step, watch,
    input  tick, halted, watch_q, changed, change_count
  );

  modport slave (
    input  mode, div_load, div_value, step, watch,
    output tick, halted, watch_q, changed, change_count
  );
endinterface

// File: rtl/debug_clock_ctrl.sv
// Programmable tick-enable generator (HALT / FREE / STEP / BREAK pacing) with a
// watched-bus change detector and saturating change counter for board bring-up.
module debug_clock_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 262144,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  debug_clock_ctrl_if.slave  bus
);

  localparam logic [2:0] S_HALT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_BRUN  = 3'd3;
  localparam logic [2:0] S_BHALT = 3'd4;

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_step_d;
  logic             r_tick;
  logic             r_halted;
  logic [WIDTH-1:0] r_watch_q;
  logic             r_changed;
  logic [CNT_W-1:0] r_change_count;

  logic [2:0]       w_next_state;
  logic             w_step_rise;
  logic             w_running;
  logic             w_wrap;
  logic             w_due;
  logic             w_state_chg;
  logic             w_diff;

  assign w_step_rise = bus.step & ~r_step_d;
  assign w_running   = (r_state == S_RUN) || (r_state == S_BRUN);
  assign w_wrap      = (r_cnt == r_div - ONE_D);
  // A change seen while break-running suppresses the tick being computed this cycle.
  assign w_due       = w_running && w_wrap && !((r_state == S_BRUN) && r_changed);
  assign w_state_chg = (w_next_state != r_state);
  assign w_diff      = (bus.watch != r_watch_q);

  // Next pacing state from mode, with break-halt held until a step edge resumes it.
  always_comb begin
    w_next_state = S_HALT;
    case (bus.mode)
      2'b00: w_next_state = S_HALT;
      2'b01: w_next_state = S_RUN;
      2'b10: w_next_state = S_STEP;
      default: begin
        if (r_state == S_BHALT)
          w_next_state = w_step_rise ? S_BRUN : S_BHALT;
        else if ((r_state == S_BRUN) && r_changed)
          w_next_state = S_BHALT;
        else
          w_next_state = S_BRUN;
      end
    endcase
  end

  // State register and its registered halted flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_HALT;
      r_halted <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == S_HALT) || (w_next_state == S_BHALT);
    end
  end

  // Divisor register and free-run counter; any reload or state change restarts the period.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div <= DIV_W'(DEFAULT_DIV);
      r_cnt <= '0;
    end else begin
      if (bus.div_load)
        r_div <= (bus.div_value == '0) ? ONE_D : bus.div_value;
      if (bus.div_load || w_state_chg)
        r_cnt <= '0;
      else if (w_running)
        r_cnt <= w_wrap ? '0 : r_cnt + ONE_D;
    end
  end

  // Tick pulse from counter wrap or single-step edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tick   <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      r_tick   <= w_due || ((r_state == S_STEP) && w_step_rise);
      r_step_d <= bus.step;
    end
  end

  // Watched-bus sampler, change pulse and saturating change counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_watch_q      <= '0;
      r_changed      <= 1'b0;
      r_change_count <= '0;
    end else begin
      r_watch_q <= bus.watch;
      r_changed <= w_diff;
      if (w_diff && (r_change_count != '1))
        r_change_count <= r_change_count + ONE_C;
    end
  end

  assign bus.tick         = r_tick;
  assign bus.halted       = r_halted;
  assign bus.watch_q      = r_watch_q;
  assign bus.changed      = r_changed;
  assign bus.change_count = r_change_count;

endmodule
